// File: rtl/jpeg_zz_pkg.sv
// Shared JPEG zig-zag constants: coefficient width, block size and the
// zig-zag <-> raster index tables used by both encoder and decoder stages.
package jpeg_zz_pkg;

   localparam int unsigned DW  = 12;
   localparam int unsigned BLK = 64;

   typedef logic signed [DW-1:0] coef_t;
   typedef logic [5:0]           idx_t;

   typedef enum logic [0:0] {StIdle, StStream} rd_state_e;

   // Entry k is the raster position {row,col} of the k-th zig-zag coefficient.
   localparam int unsigned ZZ2RASTER [BLK] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   localparam int unsigned RASTER2ZZ [BLK] = '{
       0,  1,  5,  6, 14, 15, 27, 28,
       2,  4,  7, 13, 16, 26, 29, 42,
       3,  8, 12, 17, 25, 30, 41, 43,
       9, 11, 18, 24, 31, 40, 44, 53,
      10, 19, 23, 32, 39, 45, 52, 54,
      20, 22, 33, 38, 46, 51, 55, 60,
      21, 34, 37, 47, 50, 56, 59, 61,
      35, 36, 48, 49, 57, 58, 62, 63
   };

endpackage

// File: rtl/izz_pingpong_ram.sv
// Two-bank 64-entry coefficient store: one synchronous write port and one
// asynchronous read port. No reset; unwritten entries hold stale data.
module izz_pingpong_ram #(
   parameter int unsigned DW = 12
) (
   input  logic          clk_in,
   input  logic          we,
   input  logic          wbank,
   input  logic [5:0]    waddr,
   input  logic [DW-1:0] wdata,
   input  logic          rbank,
   input  logic [5:0]    raddr,
   output logic [DW-1:0] rdata
);
   import jpeg_zz_pkg::*;

   logic [DW-1:0] mem [2][BLK];

   always_ff @(posedge clk_in) begin
      if (we) begin
         mem[wbank][waddr] <= wdata;
      end
   end

   assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/inverse_zig_zag.sv
// Inverse zig-zag: buffers zig-zag ordered coefficients in a ping-pong store and
// replays each block in raster order. IZZ_ZERO_FILL_EN adds per-bank written bitmaps.
module inverse_zig_zag #(
   parameter int unsigned DW    = 12,
   parameter int unsigned NBANK = 2
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [5:0]    in_addr,
   input  logic [DW-1:0] in_data,
   input  logic          eob_in,
   input  logic          eof_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [5:0]    out_addr,
   output logic [DW-1:0] out_data,
   output logic          idct_start,
   output logic          eof_out
);
   import jpeg_zz_pkg::*;

   localparam int unsigned BW = $clog2(NBANK);
   typedef logic [BW-1:0] bank_t;

   rd_state_e        state_q, state_d;
   bank_t            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [NBANK-1:0] full_q, full_d, beof_q, beof_d;
   logic             wr_en, blk_close, release_bank;
   logic             valid_d, start_d, eof_out_d;
   idx_t             wr_raster, rd_addr, addr_d;
   logic [DW-1:0]    ram_rdata, rd_data, data_d;

   assign in_ready  = ~full_q[wr_bank_q];
   assign wr_en     = in_valid & in_ready;
   assign wr_raster = idx_t'(ZZ2RASTER[in_addr]);
   assign rd_addr   = (state_q == StStream) ? out_addr + 6'd1 : 6'd0;

`ifdef IZZ_ZERO_FILL_EN
   logic [BLK-1:0] written_q [NBANK];
   logic [BLK-1:0] written_d [NBANK];

   assign blk_close = wr_en & ((in_addr == 6'd63) | eob_in);

   always_comb begin
      written_d = written_q;
      if (wr_en) written_d[wr_bank_q][wr_raster] = 1'b1;
      if (release_bank) written_d[rd_bank_q] = '0;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) written_q <= '{default: '0};
      else        written_q <= written_d;
   end

   // Positions never written in this block read back as zero.
   assign rd_data = written_q[rd_bank_q][rd_addr] ? ram_rdata : '0;
`else
   logic unused_eob;

   assign blk_close  = wr_en & (in_addr == 6'd63);
   assign unused_eob = eob_in;
   assign rd_data    = ram_rdata;
`endif

   izz_pingpong_ram #(
      .DW (DW)
   ) u_ram (
      .clk_in (clk_in),
      .we     (wr_en),
      .wbank  (wr_bank_q),
      .waddr  (wr_raster),
      .wdata  (in_data),
      .rbank  (rd_bank_q),
      .raddr  (rd_addr),
      .rdata  (ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = out_valid;
      addr_d       = out_addr;
      data_d       = out_data;
      start_d      = 1'b0;
      eof_out_d    = 1'b0;
      release_bank = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (full_q[rd_bank_q]) begin
               state_d = StStream;
               valid_d = 1'b1;
               addr_d  = 6'd0;
               data_d  = rd_data;
               start_d = 1'b1;
            end
         end
         StStream: begin
            if (out_valid && out_ready) begin
               if (out_addr == 6'd63) begin
                  state_d      = StIdle;
                  valid_d      = 1'b0;
                  release_bank = 1'b1;
                  eof_out_d    = beof_q[rd_bank_q];
               end else begin
                  addr_d = out_addr + 6'd1;
                  data_d = rd_data;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A close on the write bank and a release of the read bank may share a cycle.
   always_comb begin
      full_d    = full_q;
      beof_d    = beof_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      if (blk_close) begin
         full_d[wr_bank_q] = 1'b1;
         beof_d[wr_bank_q] = eof_in;
         wr_bank_d         = wr_bank_q + bank_t'(1);
      end
      if (release_bank) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = rd_bank_q + bank_t'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_bank_q  <= '0;
         rd_bank_q  <= '0;
         full_q     <= '0;
         beof_q     <= '0;
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         idct_start <= 1'b0;
         eof_out    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         beof_q     <= beof_d;
         out_valid  <= valid_d;
         out_addr   <= addr_d;
         out_data   <= data_d;
         idct_start <= start_d;
         eof_out    <= eof_out_d;
      end
   end

   // A refused write must be held unchanged until it is accepted.
   hold_refused_write: assert property (@(posedge clk_in) disable iff (!rst_n)
      (in_valid && !in_ready) |=> (in_valid && $stable(in_addr) && $stable(in_data)));

endmodule

// File: tb/tb_inverse_zig_zag.sv
// Directed self-checking bench for inverse_zig_zag; the zero-fill scenario runs
// only when IZZ_ZERO_FILL_EN is defined.
module tb_inverse_zig_zag;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_addr = '0;
   logic [11:0] in_data = '0;
   logic        eob_in = 1'b0;
   logic        eof_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [5:0]  out_addr;
   logic [11:0] out_data;
   logic        idct_start;
   logic        eof_out;

   always #5 clk_in = ~clk_in;

   inverse_zig_zag dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .eob_in     (eob_in),
      .eof_in     (eof_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .idct_start (idct_start),
      .eof_out    (eof_out)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int r2zz [64];

   // Output monitor, sampled on the rising edge before the DUT updates.
   int          cyc = 0;
   logic [5:0]  q_addr [$];
   logic [11:0] q_data [$];
   int          q_cyc [$];
   int          n_start = 0, start_bad = 0, n_eof = 0, eof_cyc = 0, ready_low = 0;
   int          stall_checks = 0, stall_bad = 0;
   logic        stall_prev = 1'b0;
   logic [5:0]  stall_addr = '0;
   logic [11:0] stall_data = '0;

   always @(posedge clk_in) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            q_addr.push_back(out_addr);
            q_data.push_back(out_data);
            q_cyc.push_back(cyc);
         end
         if (stall_prev) begin
            stall_checks <= stall_checks + 1;
            if (out_addr !== stall_addr || out_data !== stall_data) stall_bad <= stall_bad + 1;
         end
         if (idct_start) begin
            n_start <= n_start + 1;
            if (!(out_valid && out_addr == 6'd0)) start_bad <= start_bad + 1;
         end
         if (eof_out) begin
            n_eof   <= n_eof + 1;
            eof_cyc <= cyc;
         end
         if (in_valid && !in_ready) ready_low <= ready_low + 1;
      end
      stall_prev <= rst_n && out_valid && !out_ready;
      stall_addr <= out_addr;
      stall_data <= out_data;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
      n_start = 0; start_bad = 0; n_eof = 0; ready_low = 0;
      stall_checks = 0; stall_bad = 0;
   endtask

   task automatic put(input int addr, input logic [11:0] data, input logic eob, input logic eof);
      int bound = 0;
      in_valid = 1'b1;
      in_addr  = 6'(addr);
      in_data  = data;
      eob_in   = eob;
      eof_in   = eof;
      while (!in_ready && bound < 1000) begin
         @(negedge clk_in);
         bound++;
      end
      if (bound >= 1000) chk("in_ready_timeout", 0, 1);
      @(negedge clk_in);
      in_valid = 1'b0;
      eob_in   = 1'b0;
      eof_in   = 1'b0;
   endtask

   task automatic write_block(input int b, input logic eof);
      for (int k = 0; k < 64; k++) put(k, 12'((b << 6) | k), 1'b0, (k == 63) ? eof : 1'b0);
   endtask

   task automatic wait_xfers(input string tag, input int n);
      int bound = 0;
      while (q_addr.size() < n && bound < 2000) begin
         @(negedge clk_in);
         bound++;
      end
      if (bound >= 2000) chk(tag, q_addr.size(), n);
   endtask

   task automatic check_block(input string tag, input int base, input int b);
      int bad = 0;
      for (int r = 0; r < 64; r++) begin
         if (q_addr[base+r] !== 6'(r) || int'(q_data[base+r]) != ((b << 6) | r2zz[r])) bad++;
      end
      chk(tag, bad, 0);
   endtask

`ifdef IZZ_ZERO_FILL_EN
   task automatic check_sparse(input string tag, input int ra, input int va,
                               input int rb, input int vb);
      int bad = 0;
      int e;
      for (int r = 0; r < 64; r++) begin
         e = (r == ra) ? va : (r == rb) ? vb : 0;
         if (q_addr[r] !== 6'(r) || int'(q_data[r]) != e) bad++;
      end
      chk(tag, bad, 0);
   endtask
`endif

   initial begin
      int idx = 0;
      int lo, hi;
      // Independent raster->zig-zag model: walk the anti-diagonals.
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) for (int row = hi; row >= lo; row--) r2zz[row*8 + s - row] = idx++;
         else            for (int row = lo; row <= hi; row++) r2zz[row*8 + s - row] = idx++;
      end

      // Reset values
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_addr", int'(out_addr), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_idct_start", int'(idct_start), 0);
      chk("rst_eof_out", int'(eof_out), 0);

      // 1: single block, data = zig-zag index
      clear_mon();
      out_ready = 1'b1;
      for (int k = 0; k < 64; k++) put(k, 12'(k), 1'b0, 1'b0);
      chk("t1_valid_at_close", int'(out_valid), 0);
      @(negedge clk_in);
      chk("t1_valid_latency", int'(out_valid), 1);
      chk("t1_start_pulse", int'(idct_start), 1);
      wait_xfers("t1_xfer_timeout", 64);
      repeat (3) @(negedge clk_in);
      chk("t1_xfer_count", q_addr.size(), 64);
      check_block("t1_block", 0, 0);
      chk("t1_r1", int'(q_data[1]), 1);
      chk("t1_r8", int'(q_data[8]), 2);
      chk("t1_r63", int'(q_data[63]), 63);
      chk("t1_start_count", n_start, 1);

      // 2 + 4: three blocks back-to-back, eof on the last
      clear_mon();
      write_block(0, 1'b0);
      write_block(1, 1'b0);
      write_block(2, 1'b1);
      wait_xfers("t2_xfer_timeout", 192);
      repeat (4) @(negedge clk_in);
      chk("t2_xfer_count", q_addr.size(), 192);
      check_block("t2_block0", 0, 0);
      check_block("t2_block1", 64, 1);
      check_block("t2_block2", 128, 2);
      chk("t2_gap01", q_cyc[64] - q_cyc[63], 2);
      chk("t2_gap12", q_cyc[128] - q_cyc[127], 2);
      chk("t2_in_ready_dropped", int'(ready_low > 0), 1);
      chk("t2_start_count", n_start, 3);
      chk("t2_start_with_r0", start_bad, 0);
      chk("t4_eof_count", n_eof, 1);
      chk("t4_eof_time", eof_cyc, q_cyc[191] + 1);

      // 3: out_ready toggling 1010
      clear_mon();
      out_ready = 1'b0;
      write_block(3, 1'b0);
      begin
         int bound = 0;
         while (q_addr.size() < 64 && bound < 400) begin
            @(negedge clk_in);
            out_ready = ~out_ready;
            bound++;
         end
      end
      out_ready = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("t3_xfer_count", q_addr.size(), 64);
      check_block("t3_block", 0, 3);
      chk("t3_stalls_seen", int'(stall_checks > 30), 1);
      chk("t3_stall_stable", stall_bad, 0);
      chk("t3_no_eof", n_eof, 0);

      // 6: reset after 30 writes
      clear_mon();
      for (int k = 0; k < 30; k++) put(k, 12'h7AA, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk_in);
      chk("t6_in_ready", int'(in_ready), 1);
      chk("t6_out_valid", int'(out_valid), 0);
      chk("t6_out_addr", int'(out_addr), 0);
      chk("t6_out_data", int'(out_data), 0);
      chk("t6_idct_start", int'(idct_start), 0);
      rst_n = 1'b1;
      @(negedge clk_in);
      clear_mon();
      write_block(5, 1'b0);
      wait_xfers("t6_xfer_timeout", 64);
      repeat (3) @(negedge clk_in);
      chk("t6_xfer_count", q_addr.size(), 64);
      check_block("t6_block", 0, 5);
      chk("t6_start_count", n_start, 1);

`ifdef IZZ_ZERO_FILL_EN
      // 5: early close with zero fill; third block reuses the first block's bank
      clear_mon();
      put(0, 12'd5, 1'b0, 1'b0);
      put(2, 12'hFFD, 1'b1, 1'b0);
      wait_xfers("t5a_xfer_timeout", 64);
      repeat (3) @(negedge clk_in);
      chk("t5a_r0", int'(q_data[0]), 5);
      chk("t5a_r8", int'(q_data[8]), 12'hFFD);
      check_sparse("t5a_block", 0, 5, 8, 12'hFFD);
      clear_mon();
      put(5, 12'd9, 1'b1, 1'b0);
      wait_xfers("t5b_xfer_timeout", 64);
      repeat (3) @(negedge clk_in);
      check_sparse("t5b_block", 2, 9, 2, 9);
      clear_mon();
      put(1, 12'd1, 1'b1, 1'b0);
      wait_xfers("t5c_xfer_timeout", 64);
      repeat (3) @(negedge clk_in);
      check_sparse("t5c_no_stale", 1, 1, 1, 1);
      chk("t5c_r8_cleared", int'(q_data[8]), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
